// File: rtl/pzx_sram_pkg.sv
// Shared definitions for the PZX SRAM arbiter: FSM encoding, requester IDs
// and default sizing.
package pzx_sram_pkg;

    localparam int unsigned AW_DEF         = 21;
    localparam int unsigned ACC_CYCLES_DEF = 2;
    localparam int unsigned DW             = 8;

    // Requester IDs double as bit positions in request/grant vectors.
    localparam int unsigned NREQ       = 2;
    localparam int unsigned REQ_PLAYER = 0;
    localparam int unsigned REQ_CPU    = 1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD       = 3'd1,
        ST_WR_SETUP = 3'd2,
        ST_WR_PULSE = 3'd3,
        ST_WR_HOLD  = 3'd4
    } state_e;

endpackage

// File: rtl/pzx_sram_arbiter_arb2_rr.sv
// arb2_rr: two-way round-robin pick.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   req_i       request vector, bit index = requester ID
//   upd_i       allow the last-grant pointer to follow this cycle's grant
//   gnt_o       one-hot grant (combinational from req_i and pointer)
module arb2_rr
    import pzx_sram_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req_i,
    input  logic            upd_i,
    output logic [NREQ-1:0] gnt_o
);

    logic last_cpu_q;
    logic last_cpu_d;

    // On a tie the requester not granted last wins.
    always_comb begin
        gnt_o = req_i;
        if (req_i[REQ_PLAYER] && req_i[REQ_CPU]) begin
            gnt_o = '0;
            if (last_cpu_q) begin
                gnt_o[REQ_PLAYER] = 1'b1;
            end else begin
                gnt_o[REQ_CPU] = 1'b1;
            end
        end
    end

    always_comb begin
        last_cpu_d = last_cpu_q;
        if (upd_i && (gnt_o != '0)) begin
            last_cpu_d = gnt_o[REQ_CPU];
        end
    end

    // Pointer resets to CPU so the player wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_cpu_q <= 1'b1;
        end else begin
            last_cpu_q <= last_cpu_d;
        end
    end

endmodule

// File: rtl/pzx_sram_arbiter.sv
// pzx_sram_arbiter: shares one async 8-bit SRAM between the PZX player
// (sequential reads) and the CPU-side loader (reads/writes), with fixed
// setup / pulse / hold sequencing and round-robin arbitration in IDLE.
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   p_req/p_addr -> p_ack/p_data      player read channel
//   c_req/c_we/c_addr/c_wdata
//                -> c_ack/c_rdata     CPU-side channel
//   sram_addr/sram_data/sram_we_n     SRAM pins (data tristated outside writes)
//   busy                              FSM is not IDLE
// Build option: PZX_SRAM_CPU_READ_EN. When undefined, CPU reads are answered
// with 8'hFF one cycle after grant without touching SRAM or the pointer.
module pzx_sram_arbiter
    import pzx_sram_pkg::*;
#(
    parameter int unsigned AW         = AW_DEF,
    parameter int unsigned ACC_CYCLES = ACC_CYCLES_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          p_req,
    input  logic [AW-1:0] p_addr,
    output logic          p_ack,
    output logic [DW-1:0] p_data,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_ack,
    output logic [DW-1:0] c_rdata,
    output logic [AW-1:0] sram_addr,
    inout  wire  [DW-1:0] sram_data,
    output logic          sram_we_n,
    output logic          busy
);

    localparam int unsigned   CW       = $clog2(ACC_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(ACC_CYCLES);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NREQ-1:0] arb_req;
    logic [NREQ-1:0] gnt;
    logic            arb_en;
    logic            stub_gnt;
    logic            stub_ack_q;
    logic            owner_cpu_q;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   wdata_q;
    logic [DW-1:0]   p_data_q;
    logic [DW-1:0]   c_rdata_q;
    logic            rd_last;
    logic            bus_drv;

`ifdef PZX_SRAM_CPU_READ_EN
    assign stub_gnt = 1'b0;
`else
    assign stub_gnt = gnt[REQ_CPU] && !c_we;
`endif

    // Arbitrate only in IDLE, and not in the cycle a stubbed CPU read is acked.
    always_comb begin
        arb_en              = (state_q == ST_IDLE) && !stub_ack_q;
        arb_req             = '0;
        arb_req[REQ_PLAYER] = p_req && arb_en;
        arb_req[REQ_CPU]    = c_req && arb_en;
    end

    arb2_rr u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req_i (arb_req),
        .upd_i (!stub_gnt),
        .gnt_o (gnt)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state; cnt runs 1..ACC_CYCLES in RD and WR_PULSE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (gnt[REQ_PLAYER] || (gnt[REQ_CPU] && !c_we && !stub_gnt)) begin
                    state_d = ST_RD;
                    cnt_d   = CW'(1);
                end else if (gnt[REQ_CPU] && c_we) begin
                    state_d = ST_WR_SETUP;
                end
            end
            ST_RD: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_WR_SETUP: begin
                state_d = ST_WR_PULSE;
                cnt_d   = CW'(1);
            end
            ST_WR_PULSE: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_WR_HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_WR_HOLD: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from registered state; read data passes through in the
    // ack cycle and is held from the capture register afterwards.
    always_comb begin
        rd_last   = (state_q == ST_RD) && (cnt_q == CNT_LAST);
        p_ack     = rd_last && !owner_cpu_q;
        c_ack     = (rd_last && owner_cpu_q) || (state_q == ST_WR_HOLD) || stub_ack_q;
        p_data    = p_ack ? sram_data : p_data_q;
        c_rdata   = (rd_last && owner_cpu_q) ? sram_data : c_rdata_q;
        sram_we_n = (state_q != ST_WR_PULSE);
        bus_drv   = (state_q == ST_WR_SETUP) || (state_q == ST_WR_PULSE) ||
                    (state_q == ST_WR_HOLD);
        busy      = (state_q != ST_IDLE);
    end

    assign sram_addr = addr_q;
    assign sram_data = bus_drv ? wdata_q : 'z;

    // Grant latches and read-data capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stub_ack_q  <= 1'b0;
            owner_cpu_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            p_data_q    <= '0;
            c_rdata_q   <= '0;
        end else begin
            stub_ack_q <= stub_gnt;
            if (gnt[REQ_PLAYER]) begin
                addr_q      <= p_addr;
                owner_cpu_q <= 1'b0;
            end else if (gnt[REQ_CPU] && !stub_gnt) begin
                addr_q      <= c_addr;
                wdata_q     <= c_wdata;
                owner_cpu_q <= 1'b1;
            end
            if (p_ack) begin
                p_data_q <= sram_data;
            end
            if (rd_last && owner_cpu_q) begin
                c_rdata_q <= sram_data;
            end else if (stub_gnt) begin
                c_rdata_q <= 8'hFF;
            end
        end
    end

endmodule
